// File: rtl/dv_pkg.sv
// Shared types and default widths for the data-valid flag reader.
package dv_pkg;

  // Reader FSM: wait for the flag, then spend one cycle pulsing the clear.
  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } dv_state_e;

  localparam int DV_DATA_W = 8;
  localparam int DV_OVR_W  = 8;

endpackage

// File: rtl/dv_rd_fifo.sv
// Register-based synchronous FIFO holding captured flag words.
// The pointers carry one extra MSB so full and empty can be told apart.
module dv_rd_fifo #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next pointer and storage values; a push and a pop may happen together.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/dv_flag_reader.sv
// Consumer side of a data-valid set/clear flag: captures each flagged word
// into a FIFO, pulses the flag clear once per capture, streams words out and
// counts words the producer overwrote or lost to the clear.
module dv_flag_reader
  import dv_pkg::*;
#(
  parameter int DATA_W = DV_DATA_W,
  parameter int DEPTH  = 4,
  parameter int OVR_W  = DV_OVR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dv_in,
  input  logic [DATA_W-1:0]      dv_data,
  input  logic                   dv_set,
  output logic                   dv_clr,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [OVR_W-1:0]       ovr_cnt,
  input  logic                   ovr_clr
);

  dv_state_e        state_q, state_d;
  logic             dv_clr_q, dv_clr_d;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             push, pop, fifo_full, fifo_empty, ovr_evt;

  dv_rd_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(dv_data),
    .pop      (pop),
    .head_data(m_data),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign dv_clr  = dv_clr_q;
  assign ovr_cnt = ovr_cnt_q;
  // A set arriving while the flag is still high, or while our clear is in
  // flight, means a word never reached the FIFO.
  assign ovr_evt = dv_set && (dv_in || (state_q == CLR));

  // Capture decision uses the registered full flag only, so a pop in the same
  // cycle does not make room for a capture until the next cycle.
  always_comb begin
    state_d  = state_q;
    dv_clr_d = 1'b0;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dv_in && !fifo_full) begin
          push     = 1'b1;
          dv_clr_d = 1'b1;
          state_d  = CLR;
        end
      end
      CLR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating overrun counter; a clear request beats a same-cycle event.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_clr) begin
      ovr_cnt_d = '0;
    end else if (ovr_evt && (ovr_cnt_q != {OVR_W{1'b1}})) begin
      ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  // State, clear pulse and overrun count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dv_clr_q  <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dv_clr_q  <= dv_clr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

endmodule

// File: tb/tb_dv_flag_reader.sv
// Self-checking bench for dv_flag_reader: a vector table for the basic
// capture/overrun flow, then hand-written multi-cycle sequences. Stream
// words are checked against a queue of words expected to be captured.
module tb_dv_flag_reader;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int OVR_W  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dv_in, dv_set, dv_clr, m_valid, m_ready, ovr_clr;
  logic [DATA_W-1:0] dv_data, m_data;
  logic [CW-1:0]     fifo_cnt;
  logic [OVR_W-1:0]  ovr_cnt;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_exp;
  int                clr_seen;

  typedef struct {
    logic       in_dv;
    logic [7:0] in_data;
    logic       in_set;
    logic       in_ready;
    logic       in_ovr_clr;
    logic       push_exp;
    logic       exp_clr;
    logic       exp_valid;
    logic [2:0] exp_cnt;
    logic [7:0] exp_ovr;
  } vec_t;

  vec_t vecs[9];

  dv_flag_reader #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .OVR_W (OVR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dv_in   (dv_in),
    .dv_data (dv_data),
    .dv_set  (dv_set),
    .dv_clr  (dv_clr),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .fifo_cnt(fifo_cnt),
    .ovr_cnt (ovr_cnt),
    .ovr_clr (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic dv, input logic [7:0] d, input logic set,
                              input logic rdy, input logic oc, input logic pe,
                              input logic e_clr, input logic e_val, input logic [2:0] e_cnt,
                              input logic [7:0] e_ovr);
    vec_t v;
    v.in_dv = dv; v.in_data = d; v.in_set = set; v.in_ready = rdy; v.in_ovr_clr = oc;
    v.push_exp = pe; v.exp_clr = e_clr; v.exp_valid = e_val; v.exp_cnt = e_cnt; v.exp_ovr = e_ovr;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one table row, check registered outputs mid-cycle, advance a cycle.
  task automatic applyStimulus(input int idx, input vec_t v);
    dv_in   = v.in_dv;
    dv_data = v.in_data;
    dv_set  = v.in_set;
    m_ready = v.in_ready;
    ovr_clr = v.in_ovr_clr;
    if (v.push_exp) exp_q.push_back(v.in_data);
    @(negedge clk);
    checkOutput($sformatf("v%0d_dv_clr", idx), 32'(dv_clr), 32'(v.exp_clr));
    checkOutput($sformatf("v%0d_m_valid", idx), 32'(m_valid), 32'(v.exp_valid));
    checkOutput($sformatf("v%0d_fifo_cnt", idx), 32'(fifo_cnt), 32'(v.exp_cnt));
    checkOutput($sformatf("v%0d_ovr_cnt", idx), 32'(ovr_cnt), 32'(v.exp_ovr));
    step();
  endtask

  // Producer writes one word: flag high until the clear lands, then low a cycle.
  task automatic writeWord(input logic [7:0] d);
    exp_q.push_back(d);
    dv_in   = 1'b1;
    dv_data = d;
    step();
    checkOutput("wr_dv_clr", 32'(dv_clr), 32'd1);
    step();
    dv_in = 1'b0;
    step();
  endtask

  // Let the stream drain, bounded by a cycle budget.
  task automatic waitDrain(input string name);
    m_ready = 1'b1;
    for (int k = 0; k < 40 && !(fifo_cnt == '0 && exp_q.size() == 0); k++) step();
    checkOutput(name, 32'(fifo_cnt == '0 && exp_q.size() == 0), 32'd1);
    m_ready = 1'b0;
  endtask

  // Scoreboard: every accepted stream word must be the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL pop_unexpected: got %02h, no word expected", m_data);
      end else begin
        sb_exp = exp_q.pop_front();
        checkOutput("pop_data", 32'(m_data), 32'(sb_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    vecs[1] = mk(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'd0);
    vecs[2] = mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
    vecs[3] = mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
    vecs[4] = mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'd0);
    vecs[5] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1);
    vecs[6] = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1);
    vecs[7] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1);
    vecs[8] = mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);

    rst_n = 1'b0; dv_in = 1'b0; dv_data = '0; dv_set = 1'b0; m_ready = 1'b0; ovr_clr = 1'b0;
    #3;
    checkOutput("rst_dv_clr", 32'(dv_clr), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    #9;
    rst_n = 1'b1;
    step();

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    $display("[TB] back-pressure with full FIFO");
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) writeWord(8'(i));
    checkOutput("bp_cnt_full", 32'(fifo_cnt), 32'd4);
    dv_in = 1'b1;
    dv_data = 8'h05;
    exp_q.push_back(8'h05);
    clr_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (dv_clr) clr_seen++;
    end
    checkOutput("bp_no_clr_when_full", 32'(clr_seen), 32'd0);
    checkOutput("bp_cnt_hold", 32'(fifo_cnt), 32'd4);
    dv_set = 1'b1;
    step();
    dv_set = 1'b0;
    checkOutput("ovr_flag_high_inc", 32'(ovr_cnt), 32'd1);
    m_ready = 1'b1;
    for (int k = 0; k < 40 && !(fifo_cnt == '0 && exp_q.size() == 0 && clr_seen > 0); k++) begin
      step();
      if (dv_clr) begin
        clr_seen++;
        dv_in = 1'b0;
      end
    end
    checkOutput("bp_drained", 32'(fifo_cnt == '0 && exp_q.size() == 0), 32'd1);
    checkOutput("bp_single_clr", 32'(clr_seen), 32'd1);
    m_ready = 1'b0;
    step();

    $display("[TB] push and pop together at two entries");
    writeWord(8'h11);
    writeWord(8'h22);
    checkOutput("pp_cnt_before", 32'(fifo_cnt), 32'd2);
    exp_q.push_back(8'h33);
    dv_in = 1'b1;
    dv_data = 8'h33;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checkOutput("pp_cnt_same", 32'(fifo_cnt), 32'd2);
    checkOutput("pp_dv_clr", 32'(dv_clr), 32'd1);
    step();
    dv_in = 1'b0;
    step();
    waitDrain("pp_drained");

    $display("[TB] overrun saturation");
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    checkOutput("sat_cleared", 32'(ovr_cnt), 32'd0);
    for (int i = 0; i < 4; i++) writeWord(8'(8'h61 + i));
    dv_in = 1'b1;
    dv_data = 8'h65;
    dv_set = 1'b1;
    for (int k = 0; k < 260; k++) step();
    dv_set = 1'b0;
    checkOutput("sat_ovr_255", 32'(ovr_cnt), 32'd255);
    checkOutput("sat_fifo_full", 32'(fifo_cnt), 32'd4);
    ovr_clr = 1'b1;
    dv_set = 1'b1;
    step();
    ovr_clr = 1'b0;
    dv_set = 1'b0;
    checkOutput("sat_clr_wins", 32'(ovr_cnt), 32'd0);
    dv_in = 1'b0;
    step();
    waitDrain("sat_drained");

    $display("[TB] reset during clear cycle");
    for (int i = 0; i < 3; i++) writeWord(8'(8'h41 + i));
    dv_in = 1'b1;
    dv_data = 8'h44;
    step();
    checkOutput("rr_dv_clr_before", 32'(dv_clr), 32'd1);
    checkOutput("rr_cnt_before", 32'(fifo_cnt), 32'd4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rr_dv_clr_reset", 32'(dv_clr), 32'd0);
    checkOutput("rr_m_valid_reset", 32'(m_valid), 32'd0);
    checkOutput("rr_cnt_reset", 32'(fifo_cnt), 32'd0);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(8'h44);
    step();
    checkOutput("rr_recapture_clr", 32'(dv_clr), 32'd1);
    checkOutput("rr_recapture_valid", 32'(m_valid), 32'd1);
    dv_in = 1'b0;
    m_ready = 1'b1;
    step();
    checkOutput("rr_clr_one_cycle", 32'(dv_clr), 32'd0);
    checkOutput("rr_cnt_final", 32'(fifo_cnt), 32'd0);
    checkOutput("rr_sb_empty", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
